// File: rtl/clk_lock_rst_seq.sv
// Staged reset sequencer for the bus clock domain, gated by a filtered PLL lock.
// Define RST_SEQ_AUTORELOCK_EN to restart after lock loss instead of latching FAULT.
module clk_lock_rst_seq #(
  parameter int NUM_STAGES = 3,
  parameter int HOLDOFF_W  = 16,
  parameter int STAGE_GAP  = 256,
  parameter int FILT_LEN   = 8
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic                  locked_in,
  input  logic                  force_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            lock_lost_cnt,
  output logic [1:0]            seq_state
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_STAGE = 2'd1,
    S_READY = 2'd2,
    S_FAULT = 2'd3
  } state_t;

`ifdef RST_SEQ_AUTORELOCK_EN
  localparam state_t LOSS_STATE = S_HOLD;
`else
  localparam state_t LOSS_STATE = S_FAULT;
`endif

  localparam logic [KW-1:0] LAST    = KW'(NUM_STAGES - 1);
  localparam logic [GW-1:0] GAP_END = GW'(STAGE_GAP - 1);
  localparam logic [FW-1:0] F_FULL  = FW'(FILT_LEN);

  logic          sync1;
  logic          sync2;
  logic          samp;
  logic          lock_f;
  logic [FW-1:0] filt_cnt;

  // force_rst restarts acquisition exactly as if lock had just risen
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n || force_rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      samp     <= 1'b0;
      filt_cnt <= '0;
      lock_f   <= 1'b0;
    end else begin
      sync1 <= locked_in;
      sync2 <= sync1;
      samp  <= sync2;
      if (!samp) begin
        filt_cnt <= '0;
        lock_f   <= 1'b0;
      end else begin
        if (filt_cnt != F_FULL) filt_cnt <= filt_cnt + FW'(1);
        lock_f <= (filt_cnt == F_FULL);
      end
    end
  end

  state_t                state;
  state_t                state_nx;
  logic [HOLDOFF_W-1:0]  hold_cnt;
  logic [HOLDOFF_W-1:0]  hold_nx;
  logic [GW-1:0]         gap_cnt;
  logic [GW-1:0]         gap_nx;
  logic [KW-1:0]         stg;
  logic [KW-1:0]         stg_nx;
  logic [NUM_STAGES-1:0] rst_nx;
  logic [7:0]            lost_nx;
  logic                  loss;

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    gap_nx   = gap_cnt;
    stg_nx   = stg;
    rst_nx   = rst_out;
    lost_nx  = lock_lost_cnt;
    loss     = ((state == S_STAGE) || (state == S_READY)) && !lock_f;
    if (loss && (lock_lost_cnt != 8'hff)) lost_nx = lock_lost_cnt + 8'd1;
    if (force_rst || loss) begin
      state_nx = force_rst ? S_HOLD : LOSS_STATE;
      hold_nx  = '0;
      gap_nx   = '0;
      stg_nx   = '0;
      rst_nx   = '1;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (!lock_f) begin
            hold_nx = '0;
          end else if (hold_cnt == '1) begin
            state_nx  = S_STAGE;
            hold_nx   = '0;
            rst_nx[0] = 1'b0;
          end else begin
            hold_nx = hold_cnt + HOLDOFF_W'(1);
          end
        end
        S_STAGE: begin
          if (stg == LAST) begin
            state_nx = S_READY;
          end else if (gap_cnt == GAP_END) begin
            gap_nx         = '0;
            stg_nx         = stg + KW'(1);
            rst_nx[stg_nx] = 1'b0;
            if (stg_nx == LAST) state_nx = S_READY;
          end else begin
            gap_nx = gap_cnt + GW'(1);
          end
        end
        S_READY: state_nx = S_READY;
        S_FAULT: state_nx = S_FAULT;
        default: state_nx = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      state         <= S_HOLD;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      stg           <= '0;
      rst_out       <= '1;
      ready         <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      state         <= state_nx;
      hold_cnt      <= hold_nx;
      gap_cnt       <= gap_nx;
      stg           <= stg_nx;
      rst_out       <= rst_nx;
      ready         <= (rst_nx == '0);
      lock_lost_cnt <= lost_nx;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_clk_lock_rst_seq.sv
// Randomised bench for clk_lock_rst_seq against an event-timing reference model.
// Builds with or without RST_SEQ_AUTORELOCK_EN.
module tb_clk_lock_rst_seq;

  localparam int NS       = 3;
  localparam int HW       = 4;
  localparam int GAP      = 4;
  localparam int FL       = 4;
  localparam int HOLD_LEN = 1 << HW;
  // lock is accepted 3+FL edges after the first high sample
  localparam int RUN_NEED = FL + 1;
`ifdef RST_SEQ_AUTORELOCK_EN
  localparam int LOSS_MODE = 0;
`else
  localparam int LOSS_MODE = 2;
`endif

  logic          bus_clk   = 1'b0;
  logic          bus_rst_n = 1'b0;
  logic          locked_in = 1'b0;
  logic          force_rst = 1'b0;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic [7:0]    lock_lost_cnt;
  logic [1:0]    seq_state;

  int checks = 0;
  int errors = 0;

  clk_lock_rst_seq #(
    .NUM_STAGES(NS),
    .HOLDOFF_W (HW),
    .STAGE_GAP (GAP),
    .FILT_LEN  (FL)
  ) dut (
    .bus_clk      (bus_clk),
    .bus_rst_n    (bus_rst_n),
    .locked_in    (locked_in),
    .force_rst    (force_rst),
    .rst_out      (rst_out),
    .ready        (ready),
    .lock_lost_cnt(lock_lost_cnt),
    .seq_state    (seq_state)
  );

  always #5 bus_clk = ~bus_clk;

  // model: 0 waiting, 1 sequencing/ready, 2 fault
  int            rh[4];
  bit            fh[4];
  bit            m_lf;
  int            mode;
  int            t_lock;
  int            entry;
  int            lost;
  int            n;
  logic [NS-1:0] e_rst;
  logic          e_ready;
  logic [1:0]    e_state;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  task automatic model_step(input bit lk, input bit clr, input bit rst);
    bit lf_now;
    int el;
    int k;
    for (int i = 3; i > 0; i--) begin
      rh[i] = rh[i-1];
      fh[i] = fh[i-1];
    end
    fh[0] = clr;
    rh[0] = clr ? 0 : (lk ? rh[1] + 1 : 0);
    if (rh[0] > 1000) rh[0] = 1000;
    lf_now = (rh[3] >= RUN_NEED) && !fh[0] && !fh[1] && !fh[2];
    if (rst) begin
      mode = 0;
      lost = 0;
    end else if (mode == 1 && !m_lf) begin
      lost = (lost < 255) ? lost + 1 : 255;
      mode = clr ? 0 : LOSS_MODE;
    end else if (clr) begin
      mode = 0;
    end else if (mode == 0 && m_lf && (n - t_lock) == HOLD_LEN) begin
      mode  = 1;
      entry = n;
    end
    if (lf_now && !m_lf) t_lock = n;
    m_lf    = lf_now;
    e_rst   = '1;
    e_ready = 1'b0;
    e_state = (mode == 2) ? 2'd3 : 2'd0;
    if (mode == 1) begin
      el = n - entry;
      k  = el / GAP;
      if (k > NS - 1) k = NS - 1;
      for (int i = 0; i <= k; i++) e_rst[i] = 1'b0;
      e_state = (k == NS - 1) ? 2'd2 : 2'd1;
      e_ready = (k == NS - 1);
    end
  endtask

  task automatic cyc(input bit lk, input bit fr, input bit rn);
    @(negedge bus_clk);
    locked_in = lk;
    force_rst = fr;
    bus_rst_n = rn;
    @(posedge bus_clk);
    model_step(lk, fr || !rn, !rn);
    #1;
    chk("rst_out", 32'(rst_out), 32'(e_rst));
    chk("ready", 32'(ready), 32'(e_ready));
    chk("seq_state", 32'(seq_state), 32'(e_state));
    chk("lost_cnt", 32'(lock_lost_cnt), 32'(lost));
    n++;
  endtask

  task automatic measure(input int budget, output int t0, output int t1,
                         output int t2);
    t0 = -1;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < budget; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (t0 < 0 && rst_out[0] === 1'b0) t0 = i;
      if (t1 < 0 && rst_out[1] === 1'b0) t1 = i;
      if (t2 < 0 && ready === 1'b1) t2 = i;
    end
  endtask

  task automatic wait_ready(input int budget);
    int i;
    i = 0;
    if (seq_state == 2'd3) cyc(1'b1, 1'b1, 1'b1);
    while (ready !== 1'b1 && i < budget) begin
      cyc(1'b1, 1'b0, 1'b1);
      i++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    int lost0;
    int len;
    bit lvl;
    for (int i = 0; i < 4; i++) begin
      rh[i] = 0;
      fh[i] = 1'b1;
    end
    m_lf   = 1'b0;
    mode   = 0;
    lost   = 0;
    n      = 0;
    t_lock = -1000;
    entry  = 0;

    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    measure(40, t0, t1, t2);
    chk("pu_rst0_edge", t0, 23);
    chk("pu_rst1_edge", t1, 27);
    chk("pu_ready_edge", t2, 31);

    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cyc((i % 4) != 3, 1'b0, 1'b1);
    chk("chatter_rst", 32'(rst_out), 32'h7);
    measure(40, t0, t1, t2);
    chk("chatter_rst0_edge", t0, 23);
    chk("chatter_lost", 32'(lock_lost_cnt), 32'd0);

    lost0 = lost;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (i == 3) chk("loss_rst_t3", 32'(rst_out), 32'h0);
      if (i == 4) chk("loss_rst_t4", 32'(rst_out), 32'h7);
    end
    chk("loss_cnt", 32'(lock_lost_cnt), 32'(lost0 + 1));
`ifdef RST_SEQ_AUTORELOCK_EN
    measure(40, t0, t1, t2);
    chk("relock_ready_edge", t2, 31);
`else
    for (int i = 0; i < 100; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("fault_state", 32'(seq_state), 32'd3);
    cyc(1'b1, 1'b1, 1'b1);
    measure(40, t0, t1, t2);
    chk("fault_exit_ready_edge", t2, 31);
`endif

    cyc(1'b1, 1'b1, 1'b1);
    lost0 = lost;
    for (int i = 0; i < 100 && rst_out !== 3'b110; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("mid_stage_reached", 32'(rst_out), 32'h6);
    cyc(1'b1, 1'b1, 1'b1);
    chk("mid_force_rst", 32'(rst_out), 32'h7);
    chk("mid_force_state", 32'(seq_state), 32'd0);
    chk("mid_force_lost", 32'(lock_lost_cnt), 32'(lost0));

    wait_ready(100);
    lost0 = lost;
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("sim_state", 32'(seq_state), 32'd0);
    chk("sim_lost", 32'(lock_lost_cnt), 32'(lost0 + 1));
    wait_ready(100);

    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(1, 50);
      lvl = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++)
        cyc(lvl, ($urandom_range(0, 99) == 0), 1'b1);
    end

    for (int s = 0; s < 300; s++) begin
      wait_ready(100);
      repeat ($urandom_range(2, 5)) cyc(1'b0, 1'b0, 1'b1);
      repeat (4) cyc(1'b1, 1'b0, 1'b1);
    end
    chk("sat_cnt", 32'(lock_lost_cnt), 32'd255);
    wait_ready(100);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b1);
    chk("sat_hold", 32'(lock_lost_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
